// File: rtl/cap_sched_pkg.sv
// Shared types and constants for the capture-buffer scheduler.
package cap_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_IQ   = 2'd1;
  localparam logic [1:0] MODE_TLM  = 2'd2;

  localparam int REQ_CORR = 0;
  localparam int REQ_HOST = 1;
  localparam int REQ_TLM  = 2;

  // Capture mode implied by a one-hot grant vector.
  function automatic logic [1:0] mode_of(input logic [2:0] gnt);
    logic [1:0] m;
    if (gnt[REQ_TLM]) begin
      m = MODE_TLM;
    end else if (gnt != 3'b000) begin
      m = MODE_IQ;
    end else begin
      m = MODE_NONE;
    end
    return m;
  endfunction

endpackage

// File: rtl/cap_sched_arb.sv
// Fixed-priority arbiter (corr > host > tlm) with telemetry starvation
// promotion; the winning grant is held in a register until cleared.
module cap_sched_arb
  import cap_sched_pkg::*;
(
  input  logic       iclk_lte,
  input  logic       ireset,
  input  logic [2:0] pend_i,
  input  logic       starve_hit_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [2:0] win_o,
  output logic [2:0] grant_o
);

  logic [2:0] grant_q;

  always_comb begin
    win_o = 3'b000;
    if (!en_i) begin
      win_o = 3'b000;
    end else if (starve_hit_i && pend_i[REQ_TLM]) begin
      win_o[REQ_TLM] = 1'b1;
    end else if (pend_i[REQ_CORR]) begin
      win_o[REQ_CORR] = 1'b1;
    end else if (pend_i[REQ_HOST]) begin
      win_o[REQ_HOST] = 1'b1;
    end else if (pend_i[REQ_TLM]) begin
      win_o[REQ_TLM] = 1'b1;
    end else begin
      win_o = 3'b000;
    end
  end

  always_ff @(posedge iclk_lte or negedge ireset) begin
    if (!ireset) begin
      grant_q <= 3'b000;
    end else if (win_o != 3'b000) begin
      grant_q <= win_o;
    end else if (clr_i) begin
      grant_q <= 3'b000;
    end else begin
      grant_q <= grant_q;
    end
  end

  assign grant_o = grant_q;

endmodule

// File: rtl/cap_sched.sv
// Capture-buffer scheduler: pending/drop bookkeeping, start/fill/drain
// sequencing with timeout guards, all outputs registered.
module cap_sched
  import cap_sched_pkg::*;
#(
  parameter int               pTO_W     = 20,
  parameter logic [pTO_W-1:0] pTO_FILL  = 20'd210000,
  parameter logic [pTO_W-1:0] pTO_DRAIN = 20'd1000000,
  parameter int               pSTARVE   = 3,
  parameter int               pDROP_W   = 16
) (
  input  logic               iclk_lte,
  input  logic               ireset,
  input  logic               ienable,
  input  logic               ireq_corr,
  input  logic               ireq_host,
  input  logic               ireq_tlm,
  input  logic               icap_done,
  input  logic               ird_done,
  output logic               ocap_start,
  output logic [1:0]         ocap_mode,
  output logic [2:0]         ogrant,
  output logic               obusy,
  output logic [2:0]         opend,
  output logic [pDROP_W-1:0] odrop_cnt,
  output logic               otimeout,
  output logic               oto_flag
);

  localparam int               STV_W     = $clog2(pSTARVE + 1);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(pSTARVE);
  localparam logic [pTO_W-1:0] TO_ONE    = pTO_W'(1);
  localparam logic [pTO_W-1:0] FILL_LAST = pTO_FILL - TO_ONE;
  localparam logic [pTO_W-1:0] DRN_LAST  = pTO_DRAIN - TO_ONE;

  state_e             state_q, state_d;
  logic [pTO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pend_q, pend_d;
  logic [pDROP_W-1:0] drop_q, drop_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [1:0]         mode_q, mode_d;
  logic               start_q, busy_q, to_q, toflag_q;
  logic [2:0]         req_s, win_s, drops_s;
  logic [1:0]         ndrop_s;
  logic [pDROP_W:0]   drop_sum_s;
  logic               to_s, leave_s;

  assign req_s = {ireq_tlm, ireq_host, ireq_corr};

  cap_sched_arb u_arb (
    .iclk_lte     (iclk_lte),
    .ireset       (ireset),
    .pend_i       (pend_q),
    .starve_hit_i (starve_q == STV_MAX),
    .en_i         (ienable && (state_q == ST_IDLE)),
    .clr_i        (leave_s),
    .win_o        (win_s),
    .grant_o      (ogrant)
  );

  always_ff @(posedge iclk_lte or negedge ireset) begin
    if (!ireset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Done pulses take precedence over an expiring timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_s != 3'b000) state_d = ST_START;
        else                 state_d = ST_IDLE;
      end
      ST_START: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
      ST_FILL: begin
        if (icap_done) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == FILL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          to_s    = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_ONE;
        end
      end
      ST_DRAIN: begin
        if (ird_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DRN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          to_s    = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign leave_s = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && (state_d == ST_IDLE);

  // A same-source request in its grant cycle re-arms the bit without counting as a drop.
  always_comb begin
    pend_d     = req_s | (pend_q & ~win_s);
    drops_s    = req_s & pend_q & ~win_s;
    ndrop_s    = {1'b0, drops_s[0]} + {1'b0, drops_s[1]} + {1'b0, drops_s[2]};
    drop_sum_s = {1'b0, drop_q} + {{(pDROP_W-1){1'b0}}, ndrop_s};
    if (drop_sum_s[pDROP_W]) drop_d = '1;
    else                     drop_d = drop_sum_s[pDROP_W-1:0];
    if (win_s[REQ_TLM]) begin
      starve_d = '0;
    end else if ((win_s != 3'b000) && pend_q[REQ_TLM] && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
    if (win_s != 3'b000) mode_d = mode_of(win_s);
    else if (leave_s)    mode_d = MODE_NONE;
    else                 mode_d = mode_q;
  end

  always_ff @(posedge iclk_lte or negedge ireset) begin
    if (!ireset) begin
      pend_q   <= 3'b000;
      drop_q   <= '0;
      starve_q <= '0;
      mode_q   <= MODE_NONE;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      toflag_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
      mode_q   <= mode_d;
      start_q  <= (state_q == ST_START);
      busy_q   <= (state_d != ST_IDLE);
      to_q     <= to_s;
      toflag_q <= toflag_q | to_s;
    end
  end

  assign ocap_start = start_q;
  assign ocap_mode  = mode_q;
  assign obusy      = busy_q;
  assign opend      = pend_q;
  assign odrop_cnt  = drop_q;
  assign otimeout   = to_q;
  assign oto_flag   = toflag_q;

endmodule

// File: tb/tb_cap_sched.sv
// Scoreboard bench for cap_sched: stimulus queues expected grants/timeouts,
// a negedge monitor pops and compares whenever the DUT pulses start/timeout.
module tb_cap_sched;

  localparam logic [19:0] TO_FILL  = 20'd40;
  localparam logic [19:0] TO_DRAIN = 20'd60;

  typedef struct {
    logic [2:0] g;
    logic [1:0] m;
    int         c;
  } exp_t;

  logic        iclk_lte, ireset, ienable;
  logic        ireq_corr, ireq_host, ireq_tlm, icap_done, ird_done;
  logic        ocap_start, obusy, otimeout, oto_flag;
  logic [1:0]  ocap_mode;
  logic [2:0]  ogrant, opend;
  logic [15:0] odrop_cnt;

  exp_t sb_q[$];
  int   to_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   e0, dcyc;

  cap_sched #(.pTO_W(20), .pTO_FILL(TO_FILL), .pTO_DRAIN(TO_DRAIN),
              .pSTARVE(3), .pDROP_W(16)) dut (
    .iclk_lte(iclk_lte), .ireset(ireset), .ienable(ienable),
    .ireq_corr(ireq_corr), .ireq_host(ireq_host), .ireq_tlm(ireq_tlm),
    .icap_done(icap_done), .ird_done(ird_done),
    .ocap_start(ocap_start), .ocap_mode(ocap_mode), .ogrant(ogrant),
    .obusy(obusy), .opend(opend), .odrop_cnt(odrop_cnt),
    .otimeout(otimeout), .oto_flag(oto_flag)
  );

  initial iclk_lte = 1'b0;
  always #5 iclk_lte = ~iclk_lte;
  always @(posedge iclk_lte) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [1:0] m, input int c);
    exp_t e;
    e.g = g; e.m = m; e.c = c;
    sb_q.push_back(e);
  endtask

  // Monitor: every start/timeout pulse is matched against the scoreboard.
  always @(negedge iclk_lte) begin
    exp_t e;
    int   t;
    if (ocap_start) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_start: got grant %b expected none (cycle %0d)", ogrant, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("start_grant", {29'd0, ogrant}, {29'd0, e.g});
        chk("start_mode", {30'd0, ocap_mode}, {30'd0, e.m});
        chk("start_busy", {31'd0, obusy}, 32'd1);
        if (e.c >= 0) chk("start_cycle", cyc, e.c);
      end
    end
    if (otimeout) begin
      if (to_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_timeout: got pulse expected none (cycle %0d)", cyc);
      end else begin
        t = to_q.pop_front();
        chk("timeout_cycle", cyc, t);
        chk("timeout_flag", {31'd0, oto_flag}, 32'd1);
        chk("timeout_grant", {29'd0, ogrant}, 32'd0);
        chk("timeout_busy", {31'd0, obusy}, 32'd0);
      end
    end
  end

  task automatic pulse(input logic [2:0] r, input logic cd, input logic rd);
    {ireq_tlm, ireq_host, ireq_corr} = r;
    icap_done = cd;
    ird_done  = rd;
    @(negedge iclk_lte);
    {ireq_tlm, ireq_host, ireq_corr} = 3'b000;
    icap_done = 1'b0;
    ird_done  = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iclk_lte);
      if (ocap_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_start_bound", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_to();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge iclk_lte);
      if (otimeout) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_timeout_bound", {31'd0, seen}, 32'd1);
  endtask

  task automatic do_seq(input int fw, input int dw);
    wait_start();
    repeat (fw) @(negedge iclk_lte);
    pulse(3'b000, 1'b1, 1'b0);
    repeat (dw) @(negedge iclk_lte);
    pulse(3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    ireset = 1'b0; ienable = 1'b0;
    {ireq_tlm, ireq_host, ireq_corr} = 3'b000;
    icap_done = 1'b0; ird_done = 1'b0;
    repeat (3) @(negedge iclk_lte);
    chk("rst_outputs", {20'd0, ocap_start, ocap_mode, ogrant, obusy, opend, otimeout, oto_flag}, 32'd0);
    chk("rst_drop", {16'd0, odrop_cnt}, 32'd0);
    ireset = 1'b1; ienable = 1'b1;
    @(negedge iclk_lte);

    // Single corr: latency, ignored ird_done in FILL, clean return to idle.
    push(3'b001, 2'd1, cyc + 3);
    pulse(3'b001, 1'b0, 1'b0);
    chk("corr_pend", {29'd0, opend}, 32'd1);
    @(negedge iclk_lte);
    chk("corr_grant", {29'd0, ogrant}, 32'd1);
    chk("corr_pend_clr", {29'd0, opend}, 32'd0);
    wait_start();
    pulse(3'b000, 1'b0, 1'b1);
    chk("rd_in_fill_ignored", {31'd0, obusy}, 32'd1);
    repeat (3) @(negedge iclk_lte);
    pulse(3'b000, 1'b1, 1'b0);
    repeat (5) @(negedge iclk_lte);
    chk("drain_busy", {31'd0, obusy}, 32'd1);
    pulse(3'b000, 1'b0, 1'b1);
    chk("corr_end", {26'd0, obusy, ogrant, ocap_mode}, 32'd0);

    // Simultaneous requests resolve corr, host, tlm.
    push(3'b001, 2'd1, -1); push(3'b010, 2'd1, -1); push(3'b100, 2'd2, -1);
    pulse(3'b111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) do_seq(3, 3);
    chk("simul_drop", {16'd0, odrop_cnt}, 32'd0);
    chk("simul_pend", {29'd0, opend}, 32'd0);

    // Starvation: three corr grants with tlm waiting, then tlm is promoted.
    push(3'b001, 2'd1, -1); push(3'b001, 2'd1, -1); push(3'b001, 2'd1, -1);
    push(3'b100, 2'd2, -1); push(3'b001, 2'd1, -1);
    pulse(3'b101, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_start();
      pulse(3'b001, 1'b0, 1'b0);
      repeat (2) @(negedge iclk_lte);
      pulse(3'b000, 1'b1, 1'b0);
      repeat (2) @(negedge iclk_lte);
      pulse(3'b000, 1'b0, 1'b1);
    end
    do_seq(2, 2);
    do_seq(2, 2);
    chk("starve_drop", {16'd0, odrop_cnt}, 32'd0);

    // Drop: second host pulse while host already pending.
    push(3'b001, 2'd1, -1); push(3'b010, 2'd1, -1);
    pulse(3'b001, 1'b0, 1'b0);
    wait_start();
    pulse(3'b010, 1'b0, 1'b0);
    pulse(3'b010, 1'b0, 1'b0);
    chk("drop_pend", {29'd0, opend}, 32'd2);
    chk("drop_cnt", {16'd0, odrop_cnt}, 32'd1);
    pulse(3'b000, 1'b1, 1'b0);
    pulse(3'b000, 1'b0, 1'b1);
    do_seq(2, 2);
    chk("drop_pend_after", {29'd0, opend}, 32'd0);

    // Fill timeout, then the pending host is served.
    push(3'b001, 2'd1, -1); push(3'b010, 2'd1, -1);
    pulse(3'b011, 1'b0, 1'b0);
    wait_start();
    e0 = cyc;
    to_q.push_back(e0 + int'(TO_FILL));
    wait_to();
    chk("to_mode_none", {30'd0, ocap_mode}, 32'd0);
    do_seq(2, 2);

    // Done on the expiry cycle wins; then the drain timeout fires.
    push(3'b001, 2'd1, -1);
    pulse(3'b001, 1'b0, 1'b0);
    wait_start();
    e0 = cyc;
    repeat (int'(TO_FILL) - 1) @(negedge iclk_lte);
    pulse(3'b000, 1'b1, 1'b0);
    chk("done_wins_busy", {31'd0, obusy}, 32'd1);
    chk("done_wins_noto", {31'd0, otimeout}, 32'd0);
    dcyc = cyc;
    to_q.push_back(dcyc + int'(TO_DRAIN));
    wait_to();

    // Disable mid-drain: sequence completes, tlm waits for re-enable.
    push(3'b001, 2'd1, -1);
    pulse(3'b001, 1'b0, 1'b0);
    wait_start();
    repeat (2) @(negedge iclk_lte);
    pulse(3'b000, 1'b1, 1'b0);
    ienable = 1'b0;
    pulse(3'b100, 1'b0, 1'b0);
    repeat (2) @(negedge iclk_lte);
    pulse(3'b000, 1'b0, 1'b1);
    repeat (6) @(negedge iclk_lte);
    chk("dis_idle", {31'd0, obusy}, 32'd0);
    chk("dis_pend", {29'd0, opend}, 32'd4);
    push(3'b100, 2'd2, cyc + 2);
    ienable = 1'b1;
    @(negedge iclk_lte);
    chk("en_grant", {29'd0, ogrant}, 32'd4);
    wait_start();
    repeat (2) @(negedge iclk_lte);
    pulse(3'b000, 1'b1, 1'b0);
    pulse(3'b000, 1'b0, 1'b1);
    chk("drop_total", {16'd0, odrop_cnt}, 32'd1);

    // Reset during FILL clears everything, including pending host.
    push(3'b001, 2'd1, -1);
    pulse(3'b011, 1'b0, 1'b0);
    wait_start();
    repeat (2) @(negedge iclk_lte);
    #3 ireset = 1'b0;
    #1;
    chk("midrst_outputs", {20'd0, ocap_start, ocap_mode, ogrant, obusy, opend, otimeout, oto_flag}, 32'd0);
    chk("midrst_drop", {16'd0, odrop_cnt}, 32'd0);
    @(negedge iclk_lte);
    ireset = 1'b1;
    repeat (5) @(negedge iclk_lte);
    chk("post_rst_idle", {28'd0, obusy, opend}, 32'd0);

    chk("sb_empty", sb_q.size(), 32'd0);
    chk("to_empty", to_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
